// File: rtl/accelerator_hls_deadlock_report_ctrl_pkg.sv
// Shared types and width helpers for the deadlock report controller.
// Imported by the controller, its encoder and its report interface.
package accelerator_hls_deadlock_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ORIGIN,
    TRACE,
    REPORT,
    LOCKED
  } state_e;

  localparam int TIMEOUT_DEF = 64;

  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/accelerator_hls_deadlock_report_ctrl_if.sv
// Report bundle between the controller and the debug/status consumer.
// Fields are held valid until the consumer acknowledges.
interface accelerator_hls_deadlock_report_ctrl_if #(
  parameter int PROC_NUM = 4,
  parameter int ORIGIN_W = 2
);

  logic                report_valid;
  logic [ORIGIN_W-1:0] report_origin;
  logic [PROC_NUM-1:0] report_members;
  logic                report_timeout;
  logic                report_ack;

  modport master (
    output report_valid,
    output report_origin,
    output report_members,
    output report_timeout,
    input  report_ack
  );

  modport slave (
    input  report_valid,
    input  report_origin,
    input  report_members,
    input  report_timeout,
    output report_ack
  );

endinterface

// File: rtl/accelerator_hls_deadlock_report_ctrl_prio_enc.sv
// Lowest-set-bit priority encoder used to pick the origin process.
// found_o flags that at least one request bit is set.
module accelerator_hls_deadlock_prio_enc
  import accelerator_hls_deadlock_pkg::*;
#(
  parameter int PROC_NUM = 4,
  parameter int ORIGIN_W = clog2w(PROC_NUM)
) (
  input  logic [PROC_NUM-1:0] vec_i,
  output logic [ORIGIN_W-1:0] idx_o,
  output logic                found_o
);

  always_comb begin
    idx_o   = '0;
    found_o = |vec_i;
    for (int i = PROC_NUM - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = ORIGIN_W'(i);
    end
  end

endmodule

// File: rtl/accelerator_hls_deadlock_report_ctrl.sv
// Deadlock report controller: selects an origin, traces the token ring
// and publishes one latched report under a valid/ack handshake.
module accelerator_hls_deadlock_report_ctrl
  import accelerator_hls_deadlock_pkg::*;
#(
  parameter int PROC_NUM  = 4,
  parameter int ORIGIN_W  = clog2w(PROC_NUM),
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter int TIMEOUT_W = 7
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                sw_clear,
  input  logic [PROC_NUM-1:0] dl_detect_vec,
  input  logic [PROC_NUM-1:0] token_active_vec,
  output logic [PROC_NUM-1:0] origin_vec,
  output logic                dl_detect_bcast,
  output logic                token_clear,
  accelerator_hls_deadlock_report_ctrl_if.master rpt
);

  state_e              state_q, state_d;
  logic [ORIGIN_W-1:0] origin_q, origin_d;
  logic [PROC_NUM-1:0] members_q, members_d;
  logic [PROC_NUM-1:0] ovec_q, ovec_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                tout_q, tout_d;
  logic [ORIGIN_W-1:0] enc_idx;
  logic                enc_found;
  logic                ret;
  logic                tmo;
  logic                valid;

  accelerator_hls_deadlock_prio_enc #(
    .PROC_NUM (PROC_NUM),
    .ORIGIN_W (ORIGIN_W)
  ) u_enc (
    .vec_i   (dl_detect_vec),
    .idx_o   (enc_idx),
    .found_o (enc_found)
  );

  assign ret = dl_detect_vec[origin_q]
             & token_active_vec[origin_q];
  assign tmo = (cnt_q == TIMEOUT_W'(TIMEOUT - 1));

  always_comb begin
    state_d         = state_q;
    origin_d        = origin_q;
    members_d       = members_q;
    ovec_d          = '0;
    cnt_d           = cnt_q;
    tout_d          = tout_q;
    dl_detect_bcast = 1'b0;
    token_clear     = 1'b0;
    valid           = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable && enc_found) begin
          origin_d = enc_idx;
          ovec_d   = PROC_NUM'(1) << enc_idx;
          state_d  = ORIGIN;
        end
      end
      ORIGIN: begin
        dl_detect_bcast = 1'b1;
        members_d       = PROC_NUM'(1) << origin_q;
        cnt_d           = '0;
        state_d         = TRACE;
      end
      TRACE: begin
        dl_detect_bcast = 1'b1;
        members_d       = members_q | token_active_vec;
        cnt_d           = cnt_q + TIMEOUT_W'(1);
        // a returning token beats a coincident timeout
        if (ret) begin
          token_clear = 1'b1;
          tout_d      = 1'b0;
          state_d     = REPORT;
        end else if (tmo) begin
          token_clear = 1'b1;
          tout_d      = 1'b1;
          state_d     = REPORT;
        end
      end
      REPORT: begin
        dl_detect_bcast = 1'b1;
        valid           = 1'b1;
        if (rpt.report_ack) state_d = LOCKED;
      end
      LOCKED: begin
        dl_detect_bcast = 1'b1;
        if (sw_clear) begin
          origin_d  = '0;
          members_d = '0;
          tout_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (reset) token_clear = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      origin_q  <= '0;
      members_q <= '0;
      ovec_q    <= '0;
      cnt_q     <= '0;
      tout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      origin_q  <= origin_d;
      members_q <= members_d;
      ovec_q    <= ovec_d;
      cnt_q     <= cnt_d;
      tout_q    <= tout_d;
    end
  end

  assign origin_vec         = ovec_q;
  assign rpt.report_valid   = valid;
  assign rpt.report_origin  = origin_q;
  assign rpt.report_members = members_q;
  assign rpt.report_timeout = tout_q;

endmodule

// File: doc/accelerator_hls_deadlock_report_ctrl.md
Name: accelerator_hls_deadlock_report_ctrl

Overview:
- Central controller on the consumer end of the per-process deadlock-detect fabric.
- Watches the dl_detect outputs of all PROC_NUM per-process detect units and picks one origin process.
- Drives origin, the dl_detect broadcast and token_clear back into the units, then follows the token around the dependency cycle.
- Publishes one latched deadlock report (origin index, member bitmap, timeout flag) to the debug/status interface under a valid/ack handshake.

Parameters:
- PROC_NUM, 4, number of dataflow processes / detect units (>=2).
- ORIGIN_W, 2, width of origin index; must equal max(1, clog2(PROC_NUM)).
- TIMEOUT, 64, TRACE-cycle limit before forced report (>=2).
- TIMEOUT_W, 7, width of trace counter; must satisfy 2^TIMEOUT_W > TIMEOUT.

Ports:
- clock  in  1  sole clock, posedge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  arms detection; sampled in IDLE only.
- sw_clear  in  1  software clear; returns LOCKED to IDLE.
- dl_detect_vec  in  PROC_NUM  bit p = dl_detect_out of detect unit p.
- token_active_vec  in  PROC_NUM  bit p = OR of unit p token_in_vec.
- origin_vec  out  PROC_NUM  one-hot origin strobe to units.
- dl_detect_bcast  out  1  fans out to every unit's dl_detect_in.
- token_clear  out  1  fans out to every unit's token_clear.
- report_valid  out  1  report held valid until ack.
- report_origin  out  ORIGIN_W  index of origin process.
- report_members  out  PROC_NUM  processes the token visited, origin included.
- report_timeout  out  1  report closed by timeout, not token return.
- report_ack  in  1  consumer acknowledge.

Behaviour:
- Reset: state=IDLE. All outputs 0, including report registers and trace counter.
- IDLE:
  - Outputs 0.
  - If enable & |dl_detect_vec: latch origin_idx = lowest set bit; go to ORIGIN.
  - Otherwise stay.
- ORIGIN (exactly 1 cycle):
  - origin_vec = 1<<origin_idx, registered; dl_detect_bcast=1.
  - members <= 1<<origin_idx; cnt <= 0; go to TRACE.
- TRACE:
  - dl_detect_bcast=1.
  - Each cycle: members <= members | token_active_vec; cnt <= cnt+1.
  - Return condition (ret) = dl_detect_vec[origin_idx] & token_active_vec[origin_idx]. When ret: token_clear=1 combinationally in that same cycle; members include that cycle's token_active_vec; timeout_flag <= 0; go to REPORT.
  - Else if cnt == TIMEOUT-1: token_clear=1 combinationally; timeout_flag <= 1; go to REPORT.
  - ret and timeout in the same cycle: ret wins (timeout_flag=0).
- REPORT:
  - dl_detect_bcast=1; report_valid=1.
  - report_origin, report_members and report_timeout are stable from the first valid cycle until the ack cycle.
  - report_ack=1 -> LOCKED next cycle; report_valid drops. No ack -> hold indefinitely.
- LOCKED:
  - dl_detect_bcast=1 to suppress re-detection; report registers keep their values; report_valid=0.
  - sw_clear=1 -> IDLE and report registers cleared.
  - dl_detect_vec activity is ignored.
- Routing rules:
  - sw_clear in any state other than LOCKED is ignored.
  - enable is ignored outside IDLE.
  - token_clear is asserted only in TRACE, in exactly one cycle per report.
- Latency: detect seen in IDLE -> origin strobe in the next cycle -> TRACE from the cycle after that.
- Reset mid-operation (any state): next cycle IDLE, all outputs 0, and token_clear is not asserted.
- Width rules:
  - cnt is unsigned TIMEOUT_W bits and never wraps, because the timeout exits TRACE first.
  - origin_idx is zero-extended into ORIGIN_W.

Decomposition:
- Package accelerator_hls_deadlock_pkg holds:
  - state enum {IDLE, ORIGIN, TRACE, REPORT, LOCKED};
  - the ORIGIN_W/TIMEOUT_W derivation function (clog2);
  - the default TIMEOUT constant.
- One sub-module: accelerator_hls_deadlock_prio_enc, a parameterised lowest-set-bit priority encoder (PROC_NUM -> ORIGIN_W plus a found flag).

Test Plan:
- Reset/idle: reset 2 cycles, enable=1, dl_detect_vec=0 for 10 cycles -> all outputs 0, state IDLE.
- Simple cycle, PROC_NUM=4: dl_detect_vec=4'b0110 in IDLE -> origin_vec=4'b0010 for exactly 1 cycle. Then token_active_vec walks 0100, 1000, 0010 with dl_detect_vec[1]=1 on the last step -> token_clear pulses 1 cycle, then report_origin=1, report_members=4'b1110, report_timeout=0.
- Handshake: hold report_ack=0 for 5 cycles -> report fields stable and report_valid=1. Ack -> LOCKED, valid=0. Further dl_detect_vec=4'b1111 -> no new origin strobe. sw_clear -> IDLE.
- Timeout, TIMEOUT=8: token never returns -> token_clear asserted in the 8th TRACE cycle, report_timeout=1, members = OR of observed token_active_vec.
- Simultaneous ret and timeout in the same cycle -> report_timeout=0; members include that cycle's tokens.
- Reset asserted mid-TRACE -> next cycle all outputs 0 with no token_clear pulse. enable=0 with dl_detect_vec!=0 -> controller stays IDLE.
